// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: multi-word add sequencer for the shared 32-bit adder.
// Feeds one word pair per cycle, LSW first, chaining the carry between words.
// Optional feature macro: ADD_SEQ_SUB_EN adds the `sub` port (A - B mode).
// The SETTLE state sits between the last RUN word and DONE so that `done`
// lands WORDS+1 cycles after start, with carry_out/overflow already valid.
module adder_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        cfg_cin,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        carry_out,
  output logic        overflow,
`ifdef ADD_SEQ_SUB_EN
  input  logic        sub,
`endif
  output logic [31:0] adder_op1,
  output logic [31:0] adder_op2,
  output logic        adder_cin,
  input  logic [31:0] adder_result,
  input  logic        adder_cout
);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;

  localparam logic [2:0] LAST = 3'(WORDS - 1);

  // Storage is sized for the largest legal WORDS; entries past WORDS stay 0.
  logic [31:0] a_q [0:7];
  logic [31:0] b_q [0:7];
  logic [31:0] r_q [0:7];

  state_t     state_q, state_d;
  logic [2:0] idx_q;
  logic       cin0_q;
  logic       sub_q;
  logic       carry_q;
  logic       carryOut_q;
  logic       overflow_q;
  logic       wrOk;
  logic       subReq;
  logic       signA, signB, signR;

`ifdef ADD_SEQ_SUB_EN
  assign subReq = sub;
`else
  assign subReq = 1'b0;
`endif

  assign wrOk = wr_en && (state_q == IDLE) && (32'(wr_addr) < WORDS);

  assign signA = a_q[LAST][31];
  assign signB = sub_q ^ b_q[LAST][31];
  assign signR = r_q[LAST][31];

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign carry_out = carryOut_q;
  assign overflow  = overflow_q;
  assign rd_data   = (32'(rd_addr) < WORDS) ? r_q[rd_addr] : 32'd0;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and adder drive; adder inputs are held at 0 outside RUN.
  always_comb begin
    state_d   = state_q;
    adder_op1 = 32'd0;
    adder_op2 = 32'd0;
    adder_cin = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        adder_op1 = a_q[idx_q];
        adder_op2 = sub_q ? ~b_q[idx_q] : b_q[idx_q];
        adder_cin = (idx_q == 3'd0) ? cin0_q : carry_q;
        if (idx_q == LAST) begin
          state_d = SETTLE;
        end
      end
      SETTLE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand writes, per-word result capture and final flag latching.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin
        a_q[i] <= 32'd0;
        b_q[i] <= 32'd0;
        r_q[i] <= 32'd0;
      end
      idx_q      <= 3'd0;
      cin0_q     <= 1'b0;
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wrOk) begin
        if (wr_sel) begin
          b_q[wr_addr] <= wr_data;
        end else begin
          a_q[wr_addr] <= wr_data;
        end
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q  <= 3'd0;
            cin0_q <= subReq ? 1'b1 : cfg_cin;
            sub_q  <= subReq;
          end
        end
        RUN: begin
          r_q[idx_q] <= adder_result;
          carry_q    <= adder_cout;
          if (idx_q != LAST) begin
            idx_q <= idx_q + 3'd1;
          end
        end
        SETTLE: begin
          carryOut_q <= carry_q;
          overflow_q <= (signA == signB) && (signR != signA);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Testbench for adder_seq_ctrl: scoreboard plus wide-integer reference model.
// Honours ADD_SEQ_SUB_EN the same way the design does.
`timescale 1ns/1ps
module tb_adder_seq_ctrl;

   localparam int W = 4;
   localparam int N = W * 32;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        cfg_cin;
   logic        wr_en;
   logic        wr_sel;
   logic [2:0]  wr_addr;
   logic [31:0] wr_data;
   logic [2:0]  rd_addr;
   logic [31:0] rd_data;
   logic        busy;
   logic        done;
   logic        carry_out;
   logic        overflow;
   logic        sub;
   logic [31:0] adder_op1;
   logic [31:0] adder_op2;
   logic        adder_cin;
   logic [31:0] adder_result;
   logic        adder_cout;

   logic [2:0]  monAddr;
   logic [2:0]  stimAddr;
   logic        monActive;

   typedef struct {
      logic [N-1:0] r;
      logic         c;
      logic         o;
      int           doneCyc;
   } exp_t;

   exp_t         expQ[$];
   int           tests;
   int           fails;
   int           doneCount;
   int           opsIssued;
   int           cyc;
   logic [N-1:0] curA;
   logic [N-1:0] curB;

   adder_seq_ctrl #(.WORDS(W)) dut (
      .clk(clk),
      .resetn(resetn),
      .start(start),
      .cfg_cin(cfg_cin),
      .wr_en(wr_en),
      .wr_sel(wr_sel),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .busy(busy),
      .done(done),
      .carry_out(carry_out),
      .overflow(overflow),
`ifdef ADD_SEQ_SUB_EN
      .sub(sub),
`endif
      .adder_op1(adder_op1),
      .adder_op2(adder_op2),
      .adder_cin(adder_cin),
      .adder_result(adder_result),
      .adder_cout(adder_cout)
   );

   // The shared adder is purely combinational.
   assign {adder_cout, adder_result} = {1'b0, adder_op1} + {1'b0, adder_op2} + {32'd0, adder_cin};

   // The monitor borrows the read port only while it sweeps a finished result.
   assign rd_addr = monActive ? monAddr : stimAddr;

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to check completion latency.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference result of a whole multi-word operation using plain wide arithmetic.
   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic cin, input logic sb, input int startCyc);
      exp_t         m;
      logic [N-1:0] beff;
      logic [N:0]   u;
      logic [N:0]   s;
      beff      = sb ? ~b : b;
      u         = {1'b0, a} + {1'b0, beff} + (N+1)'(sb ? 1'b1 : cin);
      s         = {a[N-1], a} + {beff[N-1], beff} + (N+1)'(sb ? 1'b1 : cin);
      m.r       = u[N-1:0];
      m.c       = u[N];
      m.o       = s[N] ^ s[N-1];
      m.doneCyc = startCyc + W + 2;
      return m;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: on every done pulse pop the oldest expectation and compare it.
   initial begin
      exp_t e;
      monActive = 1'b0;
      monAddr   = 3'd0;
      forever begin
         @(negedge clk);
         if (resetn && done) begin
            doneCount++;
            if (expQ.size() == 0) begin
               checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("done_latency", 32'(cyc), 32'(e.doneCyc));
               checkOutput("carry_out", {31'd0, carry_out}, {31'd0, e.c});
               checkOutput("overflow", {31'd0, overflow}, {31'd0, e.o});
               checkOutput("busy_in_done", {31'd0, busy}, 32'd1);
               monActive = 1'b1;
               for (int k = 0; k < 8; k++) begin
                  monAddr = 3'(k);
                  #0.5;
                  if (k < W) begin
                     checkOutput($sformatf("R%0d", k), rd_data, e.r[k*32 +: 32]);
                  end else begin
                     checkOutput($sformatf("rd_oob%0d", k), rd_data, 32'd0);
                  end
               end
               monActive = 1'b0;
            end
         end
      end
   end

   // Drives one operand word; entered and left #1 after a rising edge.
   task automatic writeWord(input logic sel, input int addr, input logic [31:0] data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = 3'(addr);
      wr_data = data;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   // Loads operands, starts an operation and waits for it to finish.
   // mode 0 = normal, 1 = poke start/A0 write during RUN, 2 = reset mid-op.
   task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                                input logic sb, input logic writeA, input int mode);
      int n;
      int startCyc;
      int dc;
      if (writeA) begin
         for (int k = 0; k < W; k++) writeWord(1'b0, k, a[k*32 +: 32]);
         curA = a;
      end
      for (int k = 0; k < W; k++) writeWord(1'b1, k, b[k*32 +: 32]);
      curB     = b;
      start    = 1'b1;
      cfg_cin  = cin;
      sub      = sb;
      startCyc = cyc;
      @(posedge clk);
      #1;
      start   = 1'b0;
      cfg_cin = 1'b0;
      sub     = 1'b0;
      checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
      if (mode == 2) begin
         dc = doneCount;
         @(posedge clk);
         #1;
         resetn = 1'b0;
         @(posedge clk);
         #1;
         resetn = 1'b1;
         curA   = '0;
         curB   = '0;
         checkOutput("abort_busy", {31'd0, busy}, 32'd0);
         for (int k = 0; k < W; k++) begin
            stimAddr = 3'(k);
            #0.5;
            checkOutput($sformatf("abort_R%0d", k), rd_data, 32'd0);
         end
         repeat (W + 4) @(posedge clk);
         #1;
         checkOutput("abort_no_done", 32'(doneCount), 32'(dc));
         return;
      end
      expQ.push_back(model(curA, curB, cin, sb, startCyc));
      opsIssued++;
      if (mode == 1) begin
         start   = 1'b1;
         wr_en   = 1'b1;
         wr_sel  = 1'b0;
         wr_addr = 3'd0;
         wr_data = 32'h12345678;
         @(posedge clk);
         #1;
         start = 1'b0;
         wr_en = 1'b0;
      end
      n = 0;
      while (busy && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy) checkOutput("busy_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Directed scenarios followed by random operations.
   initial begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         sb;
      tests = 0; fails = 0; doneCount = 0; opsIssued = 0;
      curA = '0; curB = '0;
      resetn = 1'b0; start = 1'b0; cfg_cin = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
      wr_addr = 3'd0; wr_data = 32'd0; stimAddr = 3'd0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_carry", {31'd0, carry_out}, 32'd0);
      checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
      checkOutput("rst_adder_op1", adder_op1, 32'd0);
      for (int k = 0; k < W; k++) begin
         stimAddr = 3'(k);
         #0.5;
         checkOutput($sformatf("rst_R%0d", k), rd_data, 32'd0);
      end
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Carry ripples through every word.
      applyStimulus({N{1'b1}}, N'(1), 1'b0, 1'b0, 1'b1, 0);
      // Carry-in alone.
      applyStimulus('0, '0, 1'b1, 1'b0, 1'b1, 0);
      // Signed overflow into the top word.
      a = {N{1'b1}};
      a[N-1 -: 32] = 32'h7FFFFFFF;
      applyStimulus(a, N'(1), 1'b0, 1'b0, 1'b1, 0);
      // Start and A0 write during RUN are ignored.
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, N'(5), 1'b0, 1'b0, 1'b1, 1);
      // Reuse stored A to show the A0 write did not land.
      applyStimulus('0, N'(7), 1'b0, 1'b0, 1'b0, 0);
      // Reset in the second RUN cycle aborts the operation.
      applyStimulus({N{1'b1}}, {N{1'b1}}, 1'b1, 1'b0, 1'b1, 2);
`ifdef ADD_SEQ_SUB_EN
      applyStimulus('0, N'(1), 1'b0, 1'b1, 1'b1, 0);
`endif
      for (int t = 0; t < 10; t++) begin
         for (int k = 0; k < W; k++) begin
            a[k*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            b[k*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
         end
`ifdef ADD_SEQ_SUB_EN
         sb = 1'($urandom_range(0, 1));
`else
         sb = 1'b0;
`endif
         applyStimulus(a, b, 1'($urandom_range(0, 1)), sb, 1'b1, 0);
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("done_count", 32'(doneCount), 32'(opsIssued));
      checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
